// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the key schedule and encryption datapath.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned NUM_KEYS   = NUM_ROUNDS + 1;

  typedef logic [127:0] round_key_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } key_state_t;

  // Round constants indexed by round number; entry 0 is unused.
  localparam logic [NUM_KEYS-1:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse (x^254) in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // Square-and-multiply chain; zero maps to zero without special casing.
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, in_byte);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, in_byte);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, in_byte);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, in_byte);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, in_byte);
    inv  = gf_mul(x127, x127);
  end

  assign out_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: latches the cipher key, derives one round key per clock into an
// 11-entry register file, and serves keys through round_key_0 and an addressed read port.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key_in,
  input  logic              key_load,
  input  logic [ADDR_W-1:0] round_key_addr,
  output logic [127:0]      round_key_input,
  output logic [127:0]      round_key_0,
  output logic              keys_ready,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d, prev_idx;
  round_key_t       rk_q [NUM_KEYS];
  round_key_t       rk_d [NUM_KEYS];
  logic             keys_ready_q, keys_ready_d;
  logic             busy_q, busy_d;
  round_key_t       prev_key, next_key;
  word_t            rot_w, sub_w, t_w, w4, w5, w6, w7;

  // Round function on the previously written key.
  assign prev_idx = (rcnt_q == '0) ? '0 : rcnt_q - CNT_W'(1);
  assign prev_key = rk_q[prev_idx];
  assign rot_w    = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*g +: 8]),
      .out_byte (sub_w[8*g +: 8])
    );
  end

  assign t_w      = sub_w ^ {RCON[rcnt_q], 24'h0};
  assign w4       = prev_key[127:96] ^ t_w;
  assign w5       = prev_key[95:64]  ^ w4;
  assign w6       = prev_key[63:32]  ^ w5;
  assign w7       = prev_key[31:0]   ^ w6;
  assign next_key = {w4, w5, w6, w7};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (key_load) state_d = EXPAND;
      EXPAND:  if (key_load) state_d = EXPAND;
               else if (rcnt_q == CNT_W'(NUM_ROUNDS)) state_d = READY;
      READY:   if (key_load) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
  end

  // A load restarts from any state; otherwise EXPAND writes one key per cycle.
  always_comb begin
    rk_d         = rk_q;
    rcnt_d       = rcnt_q;
    keys_ready_d = keys_ready_q;
    busy_d       = busy_q;
    if (key_load) begin
      rk_d[0]      = key_in;
      rcnt_d       = CNT_W'(1);
      keys_ready_d = 1'b0;
      busy_d       = 1'b1;
    end else if (state_q == EXPAND) begin
      rk_d[rcnt_q] = next_key;
      if (rcnt_q == CNT_W'(NUM_ROUNDS)) begin
        keys_ready_d = 1'b1;
        busy_d       = 1'b0;
      end else begin
        rcnt_d = rcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_q         <= '{default: '0};
      rcnt_q       <= '0;
      keys_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rk_q         <= rk_d;
      rcnt_q       <= rcnt_d;
      keys_ready_q <= keys_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign round_key_input = (round_key_addr < ADDR_W'(NUM_KEYS))
                         ? rk_q[round_key_addr[CNT_W-1:0]] : '0;
  assign round_key_0     = rk_q[0];
  assign keys_ready      = keys_ready_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: FIPS-197 vectors plus random keys against a
// word-level FIPS key-schedule model with a log/antilog S-box.
module tb_aes_key_expansion;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic [4:0]   round_key_addr;
  logic [127:0] round_key_input;
  logic [127:0] round_key_0;
  logic         keys_ready;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]   exp_t [256];
  int           log_t [256];
  logic [127:0] exp_rk [11];

  aes_key_expansion dut (
    .clk             (clk),
    .rst             (rst),
    .key_in          (key_in),
    .key_load        (key_load),
    .round_key_addr  (round_key_addr),
    .round_key_input (round_key_input),
    .round_key_0     (round_key_0),
    .keys_ready      (keys_ready),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b};
    return d[15-k -: 8];
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv;
    if (x == 8'h00) inv = 8'h00;
    else            inv = exp_t[(255 - log_t[x]) % 255];
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  task automatic build_tables();
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = i;
      p = p ^ xt(p);
    end
    exp_t[255] = 8'h01;
    log_t[0]   = 0;
  endtask

  // FIPS-197 KeyExpansion over 44 words.
  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, output logic [127:0] v);
    round_key_addr = 5'(a);
    #1;
    v = round_key_input;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [127:0] v;
    for (int a = 0; a < 11; a++) begin
      rd(a, v);
      chk($sformatf("%s_rk%0d", tag, a), v, exp_rk[a]);
    end
    chk({tag, "_rk0port"}, round_key_0, exp_rk[0]);
  endtask

  task automatic check_oor(input string tag);
    logic [127:0] v;
    rd(11, v); chk({tag, "_oor11"}, v, 128'h0);
    rd(20, v); chk({tag, "_oor20"}, v, 128'h0);
    rd(31, v); chk({tag, "_oor31"}, v, 128'h0);
  endtask

  // Load a key and check flags edge by edge until the schedule completes.
  task automatic expand_check(input logic [127:0] k, input string tag);
    logic [127:0] v;
    int oor [3];
    oor[0] = 11; oor[1] = 20; oor[2] = 31;
    build_model(k);
    load_key(k);
    chk({tag, "_busy_e0"}, 128'(busy), 128'h1);
    chk({tag, "_ready_e0"}, 128'(keys_ready), 128'h0);
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk($sformatf("%s_busy_e%0d", tag, n), 128'(busy), 128'h1);
      chk($sformatf("%s_ready_e%0d", tag, n), 128'(keys_ready), 128'h0);
      chk($sformatf("%s_rk0_e%0d", tag, n), round_key_0, k);
      rd(oor[n % 3], v);
      chk($sformatf("%s_oor_e%0d", tag, n), v, 128'h0);
    end
    tick();
    chk({tag, "_ready_e10"}, 128'(keys_ready), 128'h1);
    chk({tag, "_busy_e10"}, 128'(busy), 128'h0);
    check_all(tag);
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] ka;
    build_tables();
    rst = 1'b0;
    key_in = '0;
    key_load = 1'b0;
    round_key_addr = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 128'(keys_ready), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_rk0", round_key_0, 128'h0);
    rd(0, v);  chk("rst_rd0", v, 128'h0);
    rd(10, v); chk("rst_rd10", v, 128'h0);
    check_oor("idle");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_ready", 128'(keys_ready), 128'h0);

    expand_check(128'h2b7e151628aed2a6abf7158809cf4f3c, "fips");
    rd(1, v);  chk("fips_a1_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(10, v); chk("fips_a1_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_oor("ready");
    for (int i = 0; i < 5; i++) tick();
    chk("hold_ready", 128'(keys_ready), 128'h1);
    check_all("hold");

    // Abort mid-expansion with an all-zero key at E4.
    ka = {$urandom, $urandom, $urandom, $urandom};
    load_key(ka);
    for (int i = 0; i < 3; i++) tick();
    chk("abort_busy_e3", 128'(busy), 128'h1);
    expand_check(128'h0, "restart");
    rd(10, v); chk("restart_zero_rk10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Reloads from READY with random keys.
    for (int it = 0; it < 4; it++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      expand_check(ka, $sformatf("reload%0d", it));
    end

    // Asynchronous reset between edges, after E5 of an expansion.
    ka = {$urandom, $urandom, $urandom, $urandom};
    load_key(ka);
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 128'(keys_ready), 128'h0);
    chk("arst_busy", 128'(busy), 128'h0);
    chk("arst_rk0", round_key_0, 128'h0);
    rd(3, v); chk("arst_rd3", v, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("arst_idle_ready%0d", i), 128'(keys_ready), 128'h0);
    end
    ka = {$urandom, $urandom, $urandom, $urandom};
    expand_check(ka, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
